instr_mem_loader: RTL and testbench

- Writer side of the processor instruction memory. Accepts a stream of instruction words and writes them into the dual-port RAM from address 0 upward.
- Holds the processor in reset (active-low) while loading, then releases it.
- Replaces bench-side direct poking of RAM contents with a synthesizable boot path. It sits between an external host link and one write port of dual_port_ram.

---
 rtl/instr_mem_loader.sv | 178 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Boot loader: streams instruction words into RAM from address 0, holds the CPU in reset
// until loaded. Optional trailer checksum enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RESET_HOLD = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_length,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_cpu_reset_n,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH:0]   o_count
);

    typedef logic [ADDR_WIDTH:0] cnt_t;
    typedef enum logic [2:0] {StIdle, StLoad, StCheck, StHold, StRun, StErr} state_t;

    localparam cnt_t Depth = cnt_t'(1 << ADDR_WIDTH);

    state_t                state_q, state_d;
    cnt_t                  len_q, len_d;
    cnt_t                  count_q, count_d;
    logic [3:0]            hold_q, hold_d;
    logic                  ready_q, ready_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

    logic length_ok;
    logic last_word;

    assign length_ok = (i_length != '0) && (i_length <= Depth);
    assign last_word = (count_q + cnt_t'(1)) == len_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        hold_d      = hold_q;
        ready_d     = ready_q;
        we_d        = 1'b0;
        addr_d      = '0;
        wdata_d     = '0;
        cpu_rst_n_d = cpu_rst_n_q;
        done_d      = done_q;
        error_d     = error_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            StIdle, StRun, StErr: begin
                // A new session always kills a running program first
                if (i_start) begin
                    cpu_rst_n_d = 1'b0;
                    done_d      = 1'b0;
                    if (length_ok) begin
                        state_d = StLoad;
                        len_d   = i_length;
                        count_d = '0;
                        ready_d = 1'b1;
                        error_d = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        sum_d   = '0;
`endif
                    end else begin
                        state_d = StErr;
                        ready_d = 1'b0;
                        error_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (i_valid && ready_q) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_WIDTH-1:0];
                    wdata_d = i_data;
                    count_d = count_q + cnt_t'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + i_data;
                    if (last_word) begin
                        state_d = StCheck;
                    end
`else
                    if (last_word) begin
                        state_d = StHold;
                        ready_d = 1'b0;
                        hold_d  = '0;
                    end
`endif
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            StCheck: begin
                // Trailer word is consumed here and never written to RAM
                if (i_valid) begin
                    ready_d = 1'b0;
                    if (i_data == sum_q) begin
                        state_d = StHold;
                        hold_d  = '0;
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            StHold: begin
                if (hold_q == 4'(RESET_HOLD)) begin
                    state_d     = StRun;
                    cpu_rst_n_d = 1'b1;
                    done_d      = 1'b1;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign o_ready       = ready_q;
    assign o_mem_we      = we_q;
    assign o_mem_addr    = addr_q;
    assign o_mem_wdata   = wdata_q;
    assign o_cpu_reset_n = cpu_rst_n_q;
    assign o_done        = done_q;
    assign o_error       = error_q;
    assign o_count       = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected RAM writes queued per session, a negedge
// monitor checks each write pulse; a RAM image model is compared at the end.
module tb_instr_mem_loader;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int RH = 2;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk;
    logic          i_reset;
    logic          i_start;
    logic [AW:0]   i_length;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic          o_cpu_reset_n;
    logic          o_done;
    logic          o_error;
    logic [AW:0]   o_count;

    int compared = 0;
    int mismatched = 0;
    int wr_count = 0;
    wr_t exp_q[$];
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_exp [DEPTH];
    logic [DW-1:0] words [DEPTH];
`ifdef INSTR_LOADER_CHECKSUM_EN
    int ck_bad = 0;
`endif

    instr_mem_loader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RESET_HOLD(RH)
    ) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_length     (i_length),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_cpu_reset_n(o_cpu_reset_n),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_count      (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM stand-in plus write scoreboard
    always @(negedge clk) begin
        if (o_mem_we === 1'b1) begin
            wr_t e;
            wr_count++;
            ram[o_mem_addr] = o_mem_wdata;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         o_mem_addr, o_mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (o_mem_addr !== e.addr || o_mem_wdata !== e.data) begin
                    mismatched++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             o_mem_addr, o_mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    // mode: 0 = valid always high, 1 = valid pattern 1,0,0, 2 = random valid
    task automatic run_session(input int len, input int mode);
        int idx = 0;
        int pat = 0;
        int budget = 0;
        int n = 0;
        int wr_before;
        logic ready_ok = 1'b1;
        logic v;
        bit released = 1'b1;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{addr: AW'(i), data: words[i]});
            ram_exp[i] = words[i];
        end
        wr_before = wr_count;
        i_length = (AW+1)'(len);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("start_cpu_reset_n", o_cpu_reset_n, 0);
        check("start_done", o_done, 0);
        check("start_count", o_count, 0);
        while (idx < len && budget < 5000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((pat % 3) == 0) : 1'($urandom_range(0, 1));
            pat++;
            i_valid = v;
            i_data = v ? words[idx] : DW'($urandom);
            if (o_ready !== 1'b1) ready_ok = 1'b0;
            tick();
            if (v) idx++;
            budget++;
        end
        i_valid = 1'b0;
        check("ready_during_load", ready_ok, 1);
        check("words_accepted", idx, len);
`ifdef INSTR_LOADER_CHECKSUM_EN
        begin
            logic [DW-1:0] sum = '0;
            for (int i = 0; i < len; i++) sum = sum + words[i];
            i_valid = 1'b1;
            i_data = sum + DW'(ck_bad);
            tick();
            i_valid = 1'b0;
            if (ck_bad != 0) begin
                released = 1'b0;
                check("ck_error", o_error, 1);
                check("ck_err_cpu_reset_n", o_cpu_reset_n, 0);
                repeat (5) tick();
                check("ck_err_cpu_held", o_cpu_reset_n, 0);
                check("ck_err_done", o_done, 0);
                check("ck_err_writes", wr_count - wr_before, len);
            end
        end
`endif
        if (released) begin
            while (o_cpu_reset_n !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            check("release_delay", n, RH + 1);
            check("done_at_release", o_done, 1);
            check("final_count", o_count, len);
            check("ready_after_load", o_ready, 0);
            check("write_pulses", wr_count - wr_before, len);
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic start_bad(input int len);
        int wr_before = wr_count;
        i_length = (AW+1)'(len);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("bad_len_error", o_error, 1);
        check("bad_len_ready", o_ready, 0);
        check("bad_len_cpu_reset_n", o_cpu_reset_n, 0);
        tick();
        check("bad_len_error_holds", o_error, 1);
        check("bad_len_no_writes", wr_count - wr_before, 0);
    endtask

    initial begin
        logic [DW-1:0] image [8];
        image = '{16'hE210, 16'h2210, 16'h4210, 16'h6210, 16'h8210, 16'hA210, 16'hC210, 16'h0610};
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0;
            ram_exp[i] = '0;
        end
        i_reset = 1'b0;
        i_start = 1'b0;
        i_length = '0;
        i_valid = 1'b0;
        i_data = '0;
        repeat (3) tick();
        check("rst_ready", o_ready, 0);
        check("rst_we", o_mem_we, 0);
        check("rst_addr", o_mem_addr, 0);
        check("rst_wdata", o_mem_wdata, 0);
        check("rst_cpu_reset_n", o_cpu_reset_n, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_count", o_count, 0);
        i_reset = 1'b1;
        tick();

        // Reference image, valid held high, then valid toggling
        for (int i = 0; i < 8; i++) words[i] = image[i];
        run_session(8, 0);
        run_session(8, 1);

        // Length boundaries
        start_bad(0);
        start_bad(DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) words[i] = DW'($urandom);
        run_session(DEPTH, 2);

        // Reset after three of eight words
        for (int i = 0; i < 8; i++) words[i] = image[i];
        run_session(8, 0);
        for (int i = 0; i < 3; i++) begin
            words[i] = DW'($urandom);
            exp_q.push_back('{addr: AW'(i), data: words[i]});
            ram_exp[i] = words[i];
        end
        i_length = 9'd8;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            i_data = words[i];
            tick();
        end
        i_valid = 1'b0;
        i_reset = 1'b0;
        tick();
        check("mid_rst_ready", o_ready, 0);
        check("mid_rst_we", o_mem_we, 0);
        check("mid_rst_addr", o_mem_addr, 0);
        check("mid_rst_cpu_reset_n", o_cpu_reset_n, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_count", o_count, 0);
        check("mid_rst_drained", exp_q.size(), 0);
        check("mid_rst_mem3_kept", ram[3], ram_exp[3]);
        i_reset = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) words[i] = DW'($urandom);
        run_session(2, 0);

        // Restart from RUN with a one-word program
        words[0] = 16'h0610;
        run_session(1, 0);
        check("restart_mem0", ram[0], 16'h0610);

        // Random sessions
        for (int s = 0; s < 4; s++) begin
            int len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) words[i] = DW'($urandom);
            run_session(len, 2);
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        words[0] = 16'h0001;
        words[1] = 16'h0002;
        ck_bad = 0;
        run_session(2, 0);
        ck_bad = 1;
        run_session(2, 0);
        check("ck_no_trailer_write", ram[2], ram_exp[2]);
`endif

        repeat (3) tick();
        for (int i = 0; i < DEPTH; i++) begin
            if (ram[i] !== ram_exp[i]) begin
                check($sformatf("ram[%0d]", i), ram[i], ram_exp[i]);
            end else begin
                compared++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
